clock_tick_gen: RTL and testbench

Multi-channel programmable clock divider and tick generator, the parametrised successor to the single fixed-ratio divider. Each of `CHANNELS` independent channels divides `fast_clock` by a runtime-programmable ratio. Each channel produces a one-cycle `tick` strobe and a flop-driven square wave `clk_out`. Ratio changes are double-buffered and take effect only at a period boundary, so display-multiplex and counter-step consumers never see a truncated or stretched period.

---
 rtl/clock_tick_gen.sv | 100 ++++++++++
 tb/tb_clock_tick_gen.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_tick_gen.sv
// Multi-channel programmable clock divider. Each channel emits a one-cycle tick and a
// registered square wave; divisor writes are double-buffered and land only on a period boundary.
module clock_tick_gen #(
  parameter int unsigned          CHANNELS  = 2,
  parameter int unsigned          DIV_WIDTH = 24,
  parameter logic [DIV_WIDTH-1:0] RESET_DIV = {DIV_WIDTH{1'b1}},
  parameter int unsigned          SEL_WIDTH = 1
) (
  input  logic                 fast_clock,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [SEL_WIDTH-1:0] cfg_sel,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 sync_restart,
  output logic [CHANNELS-1:0]  tick,
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  pending
);

  typedef logic [DIV_WIDTH-1:0] div_t;

  typedef struct packed {
    div_t count;
    div_t div_act;
    div_t div_sh;
    logic pend;
    logic clk;
  } chan_t;

  localparam chan_t RESET_STATE = '{
    count:   '0,
    div_act: RESET_DIV,
    div_sh:  RESET_DIV,
    pend:    1'b0,
    clk:     1'b0
  };

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    chan_t st_q;
    chan_t st_d;
    logic  running;
    logic  terminal;
    logic  sel_hit;

    assign running  = (st_q.div_act != '0);
    assign terminal = running && (st_q.count == st_q.div_act);
    assign sel_hit  = cfg_we && (cfg_sel == SEL_WIDTH'(ch));

    // NOTE: st_d starts as a full copy of st_q so every path assigns every field and no latch is inferred.
    always_comb begin
      st_d       = st_q;
      st_d.count = running ? st_q.count + div_t'(1) : '0;

      if (terminal) begin
        st_d.count = '0;
        if (st_q.pend) begin
          st_d.div_act = st_q.div_sh;
          st_d.pend    = 1'b0;
        end
      end

      if (sel_hit) begin
        st_d.div_sh = cfg_div;
        if (!running || terminal) begin
          st_d.div_act = cfg_div;
          st_d.count   = '0;
          st_d.pend    = 1'b0;
        end else begin
          st_d.pend = 1'b1;
        end
      end

      // Restart applies whatever shadow is waiting, including one written this cycle.
      if (sync_restart) begin
        st_d.count = '0;
        if (st_d.pend) begin
          st_d.div_act = st_d.div_sh;
        end
        st_d.pend = 1'b0;
      end

      st_d.clk = !sync_restart && (st_d.count > (st_d.div_act >> 1));
    end

    // NOTE: state flops use non-blocking assignments only; every field is reset so a
    // channel comes out of reset running at the legacy rate with nothing pending.
    always_ff @(posedge fast_clock or negedge rst) begin
      if (!rst) begin
        st_q <= RESET_STATE;
      end else begin
        st_q <= st_d;
      end
    end

    assign tick[ch]    = terminal && !sync_restart;
    assign clk_out[ch] = st_q.clk;
    assign pending[ch] = st_q.pend;
  end

endmodule

// File: tb/tb_clock_tick_gen.sv
// Bench for clock_tick_gen: directed scenarios plus random traffic, each cycle compared
// against a model that tracks only position within the period and the queued divisor.
module tb_clock_tick_gen;
  localparam int NCH = 2;
  localparam int DW  = 8;
  localparam int SW  = 2;
  localparam logic [DW-1:0] RDIV = 8'd15;
  localparam int RPER = 16;

  logic           fast_clock   = 1'b0;
  logic           rst          = 1'b1;
  logic           cfg_we       = 1'b0;
  logic [SW-1:0]  cfg_sel      = '0;
  logic [DW-1:0]  cfg_div      = '0;
  logic           sync_restart = 1'b0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] pending;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: cycles into the current period, active and queued divisors.
  int unsigned m_pos [NCH];
  int unsigned m_per [NCH];
  int unsigned m_sh  [NCH];
  bit          m_pend[NCH];

  logic [NCH-1:0] o_tick, o_clk, o_pend;
  logic [NCH-1:0] e_tick, e_clk, e_pend;

  clock_tick_gen #(
    .CHANNELS (NCH),
    .DIV_WIDTH(DW),
    .RESET_DIV(RDIV),
    .SEL_WIDTH(SW)
  ) dut (
    .fast_clock  (fast_clock),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_div     (cfg_div),
    .sync_restart(sync_restart),
    .tick        (tick),
    .clk_out     (clk_out),
    .pending     (pending)
  );

  always #5 fast_clock = ~fast_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic void model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_pos[ch]  = 0;
      m_per[ch]  = RDIV;
      m_sh[ch]   = RDIV;
      m_pend[ch] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input logic we, input logic [SW-1:0] sel,
                                     input logic [DW-1:0] div, input logic rs);
    bit run;
    bit fin;
    bit hit;
    for (int ch = 0; ch < NCH; ch++) begin
      run = (m_per[ch] != 0);
      fin = run && (m_pos[ch] == m_per[ch]);
      hit = we && (int'(sel) == ch);
      m_pos[ch] = (run && !fin) ? m_pos[ch] + 1 : 0;
      if (fin && m_pend[ch]) begin
        m_per[ch]  = m_sh[ch];
        m_pend[ch] = 1'b0;
      end
      if (hit) begin
        if (!run || fin) begin
          m_per[ch]  = div;
          m_pos[ch]  = 0;
          m_pend[ch] = 1'b0;
        end else begin
          m_sh[ch]   = div;
          m_pend[ch] = 1'b1;
        end
      end
      if (rs) begin
        m_pos[ch] = 0;
        if (m_pend[ch]) m_per[ch] = m_sh[ch];
        m_pend[ch] = 1'b0;
      end
    end
  endfunction

  // One clock cycle: drive inputs, snapshot DUT outputs and model predictions, clock both.
  task automatic step(input logic we, input logic [SW-1:0] sel,
                      input logic [DW-1:0] div, input logic rs);
    cyc++;
    cfg_we = we; cfg_sel = sel; cfg_div = div; sync_restart = rs;
    #1;
    o_tick = tick; o_clk = clk_out; o_pend = pending;
    for (int ch = 0; ch < NCH; ch++) begin
      e_tick[ch] = (m_per[ch] != 0) && (m_pos[ch] == m_per[ch]) && !rs;
      e_clk[ch]  = (m_per[ch] != 0) && (m_pos[ch] > m_per[ch] / 2);
      e_pend[ch] = m_pend[ch];
    end
    @(posedge fast_clock);
    model_edge(we, sel, div, rs);
    @(negedge fast_clock);
  endtask

  task automatic test_reset();
    int start;
    int prev;
    int nt;
    int highs;
    model_reset();
    #1 rst = 1'b0;
    #2;
    total++;
    if ({tick, clk_out, pending} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b want=0", {tick, clk_out, pending});
    end
    repeat (2) @(negedge fast_clock);
    rst = 1'b1;
    start = cyc; prev = -1; nt = 0; highs = 0;
    for (int i = 0; i < 48; i++) begin
      step(1'b0, '0, '0, 1'b0);
      total++;
      if ({o_tick, o_clk, o_pend} !== {e_tick, e_clk, e_pend}) begin
        bad++; $display("FAIL reset_lockstep cyc=%0d got=%b want=%b", cyc, {o_tick, o_clk, o_pend}, {e_tick, e_clk, e_pend});
      end
      if (i < RPER) highs += int'(o_clk[0]);
      if (o_tick[0]) begin
        total++;
        if ((prev < 0 && cyc - start != RPER) || (prev >= 0 && cyc - prev != RPER)) begin
          bad++; $display("FAIL reset_tick_spacing cyc=%0d prev=%0d start=%0d want gap=%0d", cyc, prev, start, RPER);
        end
        prev = cyc; nt++;
      end
    end
    total++;
    if (nt != 3) begin bad++; $display("FAIL reset_tick_count got=%0d want=3", nt); end
    total++;
    if (highs != RPER / 2) begin bad++; $display("FAIL reset_duty got=%0d want=%0d", highs, RPER / 2); end
  endtask

  task automatic test_ratio_change();
    int t0;
    int highs;
    int tq[$];
    step(1'b1, 2'd1, 8'd9, 1'b1);
    t0 = -1;
    for (int k = 0; k < 30 && t0 < 0; k++) begin
      step(1'b0, '0, '0, 1'b0);
      total++;
      if ({o_tick, o_clk, o_pend} !== {e_tick, e_clk, e_pend}) begin
        bad++; $display("FAIL ratio_lockstep cyc=%0d got=%b want=%b", cyc, {o_tick, o_clk, o_pend}, {e_tick, e_clk, e_pend});
      end
      if (o_tick[1]) t0 = cyc;
    end
    total++;
    if (t0 < 0) begin bad++; $display("FAIL ratio_first_tick got=none want=tick within 30"); end
    for (int k = 0; k < 20 && m_pos[1] != 2; k++) step(1'b0, '0, '0, 1'b0);
    step(1'b1, 2'd1, 8'd4, 1'b0);
    highs = 0;
    for (int k = 0; k < 25; k++) begin
      step(1'b0, '0, '0, 1'b0);
      total++;
      if ({o_tick, o_clk, o_pend} !== {e_tick, e_clk, e_pend}) begin
        bad++; $display("FAIL ratio_lockstep cyc=%0d got=%b want=%b", cyc, {o_tick, o_clk, o_pend}, {e_tick, e_clk, e_pend});
      end
      total++;
      if (o_pend[1] !== (tq.size() == 0)) begin
        bad++; $display("FAIL ratio_pending cyc=%0d got=%b want=%b", cyc, o_pend[1], tq.size() == 0);
      end
      if (tq.size() == 1) highs += int'(o_clk[1]);
      if (o_tick[1]) tq.push_back(cyc);
    end
    total++;
    if (tq.size() < 3 || tq[0] - t0 != 10) begin
      bad++; $display("FAIL ratio_old_gap got=%0d want=10", tq.size() > 0 ? tq[0] - t0 : -1);
    end
    total++;
    if (tq.size() < 3 || tq[1] - tq[0] != 5 || tq[2] - tq[1] != 5) begin
      bad++; $display("FAIL ratio_new_gap ticks=%0d want gaps of 5", tq.size());
    end
    total++;
    if (highs != 2) begin bad++; $display("FAIL ratio_duty got=%0d want=2", highs); end
  endtask

  task automatic test_halt();
    int w;
    step(1'b1, 2'd0, 8'd0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, '0, '0, 1'b0);
      total++;
      if ({o_tick, o_clk, o_pend} !== {e_tick, e_clk, e_pend}) begin
        bad++; $display("FAIL halt_lockstep cyc=%0d got=%b want=%b", cyc, {o_tick, o_clk, o_pend}, {e_tick, e_clk, e_pend});
      end
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0, '0, 1'b0);
      total++;
      if ({o_tick[0], o_clk[0], o_pend[0]} !== 3'b000) begin
        bad++; $display("FAIL halt_quiet cyc=%0d got=%b want=000", cyc, {o_tick[0], o_clk[0], o_pend[0]});
      end
    end
    step(1'b1, 2'd0, 8'd2, 1'b0);
    w = cyc;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0, '0, 1'b0);
      total++;
      if (o_tick[0] !== ((cyc - w) % 3 == 0)) begin
        bad++; $display("FAIL halt_restart_tick cyc=%0d since_write=%0d got=%b", cyc, cyc - w, o_tick[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int b;
    for (int k = 0; k < 20 && !(m_per[1] != 0 && m_pos[1] == m_per[1]); k++) step(1'b0, '0, '0, 1'b0);
    step(1'b1, 2'd1, 8'd6, 1'b0);
    w = cyc;
    total++;
    if (o_tick[1] !== 1'b1) begin bad++; $display("FAIL term_write_tick got=%b want=1", o_tick[1]); end
    for (int k = 0; k < 14; k++) begin
      step(1'b0, '0, '0, 1'b0);
      total++;
      if ({o_tick[1], o_pend[1]} !== {((cyc - w) % 7 == 0), 1'b0}) begin
        bad++; $display("FAIL term_write_period cyc=%0d got=%b since_write=%0d", cyc, {o_tick[1], o_pend[1]}, cyc - w);
      end
    end
    step(1'b1, 2'd1, 8'd7, 1'b0);
    b = cyc;
    step(1'b1, 2'd1, 8'd3, 1'b0);
    total++;
    if (o_pend[1] !== 1'b1) begin bad++; $display("FAIL b2b_pending_rise got=%b want=1", o_pend[1]); end
    for (int k = 0; k < 16; k++) begin
      step(1'b0, '0, '0, 1'b0);
      total++;
      if ({o_tick[1], o_pend[1]} !== {(cyc == b + 6 || cyc == b + 10 || cyc == b + 14), (cyc <= b + 6)}) begin
        bad++; $display("FAIL b2b_sequence cyc=%0d since_first_write=%0d got=%b", cyc, cyc - b, {o_tick[1], o_pend[1]});
      end
      total++;
      if ({o_tick, o_clk, o_pend} !== {e_tick, e_clk, e_pend}) begin
        bad++; $display("FAIL b2b_lockstep cyc=%0d got=%b want=%b", cyc, {o_tick, o_clk, o_pend}, {e_tick, e_clk, e_pend});
      end
    end
  endtask

  task automatic test_sync_restart();
    int r;
    step(1'b1, 2'd0, 8'd5, 1'b0);
    step(1'b1, 2'd1, 8'd7, 1'b0);
    repeat (20 + $urandom_range(0, 11)) step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    r = cyc;
    for (int k = 0; k < 50; k++) begin
      step(1'b0, '0, '0, 1'b0);
      total++;
      if (o_tick !== {((cyc - r) % 8 == 0), ((cyc - r) % 6 == 0)}) begin
        bad++; $display("FAIL restart_phase cyc=%0d since_restart=%0d got=%b", cyc, cyc - r, o_tick);
      end
      if (cyc - r == 48) begin
        total++;
        if (o_tick !== 2'b11) begin bad++; $display("FAIL restart_coincide got=%b want=11", o_tick); end
      end
    end
    for (int k = 0; k < 10 && m_pos[0] != m_per[0]; k++) step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    total++;
    if (o_tick[0] !== 1'b0) begin bad++; $display("FAIL restart_suppresses_tick got=%b want=0", o_tick[0]); end
    total++;
    if ({o_tick, o_clk, o_pend} !== {e_tick, e_clk, e_pend}) begin
      bad++; $display("FAIL restart_lockstep cyc=%0d got=%b want=%b", cyc, {o_tick, o_clk, o_pend}, {e_tick, e_clk, e_pend});
    end
  endtask

  task automatic test_reset_midperiod();
    int start;
    int prev;
    for (int k = 0; k < 10 && m_pos[0] != 1; k++) step(1'b0, '0, '0, 1'b0);
    step(1'b1, 2'd0, 8'd9, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    #1;
    total++;
    if ({clk_out[0], pending[0]} !== 2'b11) begin
      bad++; $display("FAIL midreset_before got=%b want=11", {clk_out[0], pending[0]});
    end
    #1 rst = 1'b0;
    #1;
    total++;
    if ({tick, clk_out, pending} !== '0) begin
      bad++; $display("FAIL midreset_async got=%b want=0", {tick, clk_out, pending});
    end
    model_reset();
    repeat (2) @(negedge fast_clock);
    rst = 1'b1;
    start = cyc; prev = -1;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, '0, '0, 1'b0);
      total++;
      if ({o_tick, o_clk, o_pend} !== {e_tick, e_clk, e_pend}) begin
        bad++; $display("FAIL midreset_lockstep cyc=%0d got=%b want=%b", cyc, {o_tick, o_clk, o_pend}, {e_tick, e_clk, e_pend});
      end
      total++;
      if (o_pend[0] !== 1'b0) begin bad++; $display("FAIL midreset_pending cyc=%0d got=1 want=0", cyc); end
      if (o_tick[0]) begin
        total++;
        if ((prev < 0 ? cyc - start : cyc - prev) != RPER) begin
          bad++; $display("FAIL midreset_period cyc=%0d got gap=%0d want=%0d", cyc, prev < 0 ? cyc - start : cyc - prev, RPER);
        end
        prev = cyc;
      end
    end
  endtask

  task automatic test_random();
    logic           we;
    logic [SW-1:0]  sel;
    logic [DW-1:0]  div;
    logic           rs;
    for (int i = 0; i < 600; i++) begin
      we  = ($urandom_range(0, 3) == 0);
      sel = SW'($urandom_range(0, 3));
      div = DW'($urandom_range(0, 12));
      rs  = ($urandom_range(0, 19) == 0);
      step(we, sel, div, rs);
      total++;
      if ({o_tick, o_clk, o_pend} !== {e_tick, e_clk, e_pend}) begin
        bad++; $display("FAIL random_lockstep cyc=%0d got=%b want=%b", cyc, {o_tick, o_clk, o_pend}, {e_tick, e_clk, e_pend});
      end
    end
  endtask

  initial begin
    test_reset();
    test_ratio_change();
    test_halt();
    test_back_to_back();
    test_sync_restart();
    test_reset_midperiod();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
